// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: per-stage control codes,
// FSM state encoding, the per-stage control vector and a saturating helper.
package pipe_ctrl_pkg;

    localparam int CTRL_W = 2;

    typedef logic [CTRL_W-1:0] ctrl_bus_t;

    // Per-stage control codes: load, hold, load bubble.
    localparam ctrl_bus_t CTRL_STATE_DEFAULT = 2'b00;
    localparam ctrl_bus_t CTRL_STATE_STALL   = 2'b01;
    localparam ctrl_bus_t CTRL_STATE_FLUSH   = 2'b10;

    // Controller FSM state encoding.
    typedef enum logic [1:0] {
        ST_RUN       = 2'b00,
        ST_MEM_STALL = 2'b01,
        ST_EX_STALL  = 2'b10,
        ST_BUBBLE    = 2'b11
    } state_e;

    // One control code per pipeline register, PC first.
    typedef struct packed {
        ctrl_bus_t pc;
        ctrl_bus_t if_id;
        ctrl_bus_t id_ex;
        ctrl_bus_t ex_mem;
        ctrl_bus_t mem_wb;
    } ctrl_vec_t;

    // 8-bit increment that sticks at 255 instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        logic [7:0] result;
        if (value == 8'hFF) begin
            result = 8'hFF;
        end else begin
            result = value + 8'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/pipe_ctrl_wdt.sv
// MEM-stall watchdog: counts consecutive cycles in which the MEM stall wins
// and raises a sticky error once the count reaches MEM_TIMEOUT. It only
// reports; it never breaks the stall.
module pipe_ctrl_wdt
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic mem_stall_i,
    output logic timeout_o
);

    localparam logic [7:0] LIMIT = 8'(MEM_TIMEOUT);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;
    logic       timeout_q;
    logic       timeout_d;

    // Next count and sticky error; the error is set on the cycle the count lands on the limit.
    always_comb begin
        cnt_d     = 8'd0;
        timeout_d = timeout_q;
        if (mem_stall_i) begin
            cnt_d = sat_inc8(cnt_q);
            if (cnt_d == LIMIT) begin
                timeout_d = 1'b1;
            end else begin
                timeout_d = timeout_q;
            end
        end else begin
            cnt_d     = 8'd0;
            timeout_d = timeout_q;
        end
    end

    // Watchdog registers, cleared immediately by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller. Decodes per-stage stall/flush codes with zero
// latency from the stall requests, the redirect and a small FSM that makes
// load-use bubbles one-shot and defers redirects that arrive during stalls.
// Optional feature macro: PIPE_CTRL_PERF_EN (stall/flush performance counters).
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_id_i,
    input  logic        stallreq_ex_i,
    input  logic        stallreq_mem_i,
    input  logic        flush_i,
    output logic [1:0]  ctrl_pc_o,
    output logic [1:0]  ctrl_if_id_o,
    output logic [1:0]  ctrl_id_ex_o,
    output logic [1:0]  ctrl_ex_mem_o,
    output logic [1:0]  ctrl_mem_wb_o,
    output logic        stall_o,
    output logic        stall_timeout_o,
    output logic [31:0] stall_cnt_o,
    output logic [31:0] flush_cnt_o
);

    state_e    state_q;
    state_e    state_d;
    logic      pend_flush_q;
    logic      pend_flush_d;
    ctrl_vec_t ctrl_s;
    logic      flush_req_s;
    logic      load_use_s;

    // Redirect is live now or was deferred; a hazard seen right after its bubble is ignored.
    assign flush_req_s = flush_i | pend_flush_q;
    assign load_use_s  = stallreq_id_i & (state_q != ST_BUBBLE);

    // Priority decode (MEM > EX > flush > load-use) plus next FSM state and deferred flush.
    always_comb begin
        ctrl_s       = '0;
        state_d      = ST_RUN;
        pend_flush_d = 1'b0;
        if (stallreq_mem_i) begin
            ctrl_s       = '{pc: CTRL_STATE_STALL, if_id: CTRL_STATE_STALL,
                             id_ex: CTRL_STATE_STALL, ex_mem: CTRL_STATE_STALL,
                             mem_wb: CTRL_STATE_FLUSH};
            state_d      = ST_MEM_STALL;
            pend_flush_d = pend_flush_q | flush_i;
        end else if (stallreq_ex_i) begin
            ctrl_s       = '{pc: CTRL_STATE_STALL, if_id: CTRL_STATE_STALL,
                             id_ex: CTRL_STATE_STALL, ex_mem: CTRL_STATE_FLUSH,
                             mem_wb: CTRL_STATE_DEFAULT};
            state_d      = ST_EX_STALL;
            pend_flush_d = pend_flush_q | flush_i;
        end else if (flush_req_s) begin
            ctrl_s       = '{pc: CTRL_STATE_DEFAULT, if_id: CTRL_STATE_FLUSH,
                             id_ex: CTRL_STATE_FLUSH, ex_mem: CTRL_STATE_DEFAULT,
                             mem_wb: CTRL_STATE_DEFAULT};
            state_d      = ST_RUN;
            pend_flush_d = 1'b0;
        end else if (load_use_s) begin
            ctrl_s       = '{pc: CTRL_STATE_STALL, if_id: CTRL_STATE_STALL,
                             id_ex: CTRL_STATE_FLUSH, ex_mem: CTRL_STATE_DEFAULT,
                             mem_wb: CTRL_STATE_DEFAULT};
            state_d      = ST_BUBBLE;
            pend_flush_d = 1'b0;
        end else begin
            ctrl_s       = '0;
            state_d      = ST_RUN;
            pend_flush_d = 1'b0;
        end
    end

    // FSM state and deferred-flush registers; reset drops any pending redirect.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_RUN;
            pend_flush_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_flush_q <= pend_flush_d;
        end
    end

    assign ctrl_pc_o     = ctrl_s.pc;
    assign ctrl_if_id_o  = ctrl_s.if_id;
    assign ctrl_id_ex_o  = ctrl_s.id_ex;
    assign ctrl_ex_mem_o = ctrl_s.ex_mem;
    assign ctrl_mem_wb_o = ctrl_s.mem_wb;
    assign stall_o       = (ctrl_s != '0);

    // The MEM stall always wins when requested, so the raw request drives the watchdog.
    pipe_ctrl_wdt #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_wdt (
        .clk         (clk),
        .rst         (rst),
        .mem_stall_i (stallreq_mem_i),
        .timeout_o   (stall_timeout_o)
    );

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] stall_cnt_d;
    logic [31:0] flush_cnt_q;
    logic [31:0] flush_cnt_d;
    logic        flush_app_s;

    // A flush is applied only when no MEM/EX stall outranks it.
    assign flush_app_s = ~stallreq_mem_i & ~stallreq_ex_i & flush_req_s;
    assign stall_cnt_d = stall_cnt_q + {31'd0, stall_o};
    assign flush_cnt_d = flush_cnt_q + {31'd0, flush_app_s};

    // Free-running performance counters, wrapping at 2^32.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`else
    assign stall_cnt_o = 32'd0;
    assign flush_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus randomized
// traffic compared against a behavioural model of the hazard rules.
module tb_pipe_ctrl;

    localparam int TO = 4;

    // Expected control vectors {pc, if_id, id_ex, ex_mem, mem_wb}.
    localparam logic [9:0] P_NONE = 10'b00_00_00_00_00;
    localparam logic [9:0] P_MEM  = 10'b01_01_01_01_10;
    localparam logic [9:0] P_EX   = 10'b01_01_01_10_00;
    localparam logic [9:0] P_FL   = 10'b00_10_10_00_00;
    localparam logic [9:0] P_LU   = 10'b01_01_10_00_00;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem, ex, fl, id;
    logic [1:0]  c_pc, c_ifid, c_idex, c_exmem, c_memwb;
    logic        stall, tmo;
    logic [31:0] scnt, fcnt;
    logic [9:0]  act;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    bit          m_bub;
    bit          m_pend;
    bit          m_to;
    int          m_run;
    logic [31:0] m_scnt;
    logic [31:0] m_fcnt;

    always #5 clk = ~clk;

    assign act = {c_pc, c_ifid, c_idex, c_exmem, c_memwb};

    pipe_ctrl #(.MEM_TIMEOUT(TO)) dut (
        .clk             (clk),
        .rst             (rst),
        .stallreq_id_i   (id),
        .stallreq_ex_i   (ex),
        .stallreq_mem_i  (mem),
        .flush_i         (fl),
        .ctrl_pc_o       (c_pc),
        .ctrl_if_id_o    (c_ifid),
        .ctrl_id_ex_o    (c_idex),
        .ctrl_ex_mem_o   (c_exmem),
        .ctrl_mem_wb_o   (c_memwb),
        .stall_o         (stall),
        .stall_timeout_o (tmo),
        .stall_cnt_o     (scnt),
        .flush_cnt_o     (fcnt)
    );

    // 4=MEM, 3=EX, 2=flush, 1=load-use, 0=none
    function automatic int winner();
        if (mem) return 4;
        if (ex) return 3;
        if (fl || m_pend) return 2;
        if (id && !m_bub) return 1;
        return 0;
    endfunction

    function automatic logic [9:0] exp_ctrl();
        case (winner())
            4: return P_MEM;
            3: return P_EX;
            2: return P_FL;
            1: return P_LU;
            default: return P_NONE;
        endcase
    endfunction

    function automatic logic [31:0] exp_scnt();
`ifdef PIPE_CTRL_PERF_EN
        return m_scnt;
`else
        return 32'd0;
`endif
    endfunction

    function automatic logic [31:0] exp_fcnt();
`ifdef PIPE_CTRL_PERF_EN
        return m_fcnt;
`else
        return 32'd0;
`endif
    endfunction

    task automatic model_reset();
        m_bub = 1'b0; m_pend = 1'b0; m_to = 1'b0; m_run = 0;
        m_scnt = 32'd0; m_fcnt = 32'd0;
    endtask

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_step();
        int w;
        w = winner();
        if (exp_ctrl() != P_NONE) m_scnt = m_scnt + 32'd1;
        if (w == 2) m_fcnt = m_fcnt + 32'd1;
        m_pend = (mem || ex) ? (m_pend || fl) : 1'b0;
        if (mem) begin
            m_run = (m_run < 255) ? m_run + 1 : 255;
            if (m_run == TO) m_to = 1'b1;
        end else begin
            m_run = 0;
        end
        m_bub = (w == 1);
    endtask

    task automatic drive(input logic a_mem, input logic a_ex, input logic a_fl, input logic a_id);
        @(negedge clk);
        mem = a_mem; ex = a_ex; fl = a_fl; id = a_id;
        #1;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        mem = 1'b0; ex = 1'b0; fl = 1'b0; id = 1'b0;
        rst = 1'b0;
        #2;
        rst = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b0; mem = 1'b0; ex = 1'b0; fl = 1'b0; id = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        checks++; if (act !== P_NONE) begin errors++; $display("FAIL reset_ctrl got %b want %b", act, P_NONE); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall); end
        checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b want 0", tmo); end
        checks++; if (scnt !== 32'd0) begin errors++; $display("FAIL reset_stall_cnt got %h want 0", scnt); end
        checks++; if (fcnt !== 32'd0) begin errors++; $display("FAIL reset_flush_cnt got %h want 0", fcnt); end
        id = 1'b1;
        #1;
        checks++; if (act !== P_LU) begin errors++; $display("FAIL reset_follow_lu got %b want %b", act, P_LU); end
        id = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Hazard held 3 cycles: bubble, ignored cycle, then the still-asserted hazard fires again.
    task automatic test_load_use();
        logic [9:0] e;
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 1'b0, i < 3);
            e = (i == 0 || i == 2) ? P_LU : P_NONE;
            checks++; if (act !== e) begin errors++; $display("FAIL load_use[%0d] got %b want %b", i, act, e); end
            checks++; if (stall !== (e != P_NONE)) begin errors++; $display("FAIL load_use_stall[%0d] got %b", i, stall); end
            tick();
        end
    endtask

    task automatic test_mem_flush();
        logic [9:0] e;
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            drive(i < 4, 1'b0, i == 1, 1'b0);
            e = (i < 4) ? P_MEM : ((i == 4) ? P_FL : P_NONE);
            checks++; if (act !== e) begin errors++; $display("FAIL mem_flush[%0d] got %b want %b", i, act, e); end
            tick();
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
`ifdef PIPE_CTRL_PERF_EN
        checks++; if (fcnt !== 32'd1) begin errors++; $display("FAIL mem_flush_cnt got %0d want 1", fcnt); end
        checks++; if (scnt !== 32'd5) begin errors++; $display("FAIL mem_stall_cnt got %0d want 5", scnt); end
`else
        checks++; if (fcnt !== 32'd0) begin errors++; $display("FAIL mem_flush_cnt got %0d want 0", fcnt); end
        checks++; if (scnt !== 32'd0) begin errors++; $display("FAIL mem_stall_cnt got %0d want 0", scnt); end
`endif
        tick();
    endtask

    task automatic test_all_three();
        logic [9:0] e;
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            drive(i == 0, i == 0, i == 0, 1'b0);
            e = (i == 0) ? P_MEM : ((i == 1) ? P_FL : P_NONE);
            checks++; if (act !== e) begin errors++; $display("FAIL all_three[%0d] got %b want %b", i, act, e); end
            tick();
        end
    endtask

    task automatic test_timeout();
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            drive(i < 6, 1'b0, 1'b0, 1'b0);
            checks++; if (tmo !== (i >= TO)) begin errors++; $display("FAIL timeout[%0d] got %b want %b", i, tmo, (i >= TO)); end
            checks++; if (act !== ((i < 6) ? P_MEM : P_NONE)) begin errors++; $display("FAIL timeout_ctrl[%0d] got %b", i, act); end
            tick();
        end
    endtask

    task automatic test_reset_mid_stall();
        apply_reset();
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        checks++; if (act !== P_EX) begin errors++; $display("FAIL rst_mid_ex0 got %b want %b", act, P_EX); end
        tick();
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        checks++; if (act !== P_EX) begin errors++; $display("FAIL rst_mid_follow got %b want %b", act, P_EX); end
        ex = 1'b0;
        #1;
        checks++; if (act !== P_NONE) begin errors++; $display("FAIL rst_mid_no_flush got %b want %b", act, P_NONE); end
        checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL rst_mid_timeout got %b want 0", tmo); end
        rst = 1'b1;
        model_reset();
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (act !== P_NONE) begin errors++; $display("FAIL rst_mid_after got %b want %b", act, P_NONE); end
        tick();
        // Watchdog count must restart from zero after a reset inside a MEM stall.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        rst = 1'b1;
        model_reset();
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(i < 3, 1'b0, 1'b0, 1'b0);
            checks++; if (tmo !== (i == 3)) begin errors++; $display("FAIL wdt_discard[%0d] got %b want %b", i, tmo, (i == 3)); end
            tick();
        end
    endtask

    task automatic test_perf_wrap();
        apply_reset();
`ifdef PIPE_CTRL_PERF_EN
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        force dut.stall_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.stall_cnt_q;
        m_scnt = 32'hFFFF_FFFF;
        ex = 1'b1;
        #1;
        checks++; if (scnt !== 32'hFFFF_FFFF) begin errors++; $display("FAIL perf_preload got %h want ffffffff", scnt); end
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (scnt !== 32'd0) begin errors++; $display("FAIL perf_wrap got %h want 0", scnt); end
        tick();
`else
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (scnt !== 32'd0) begin errors++; $display("FAIL perf_off_stall got %h want 0", scnt); end
        checks++; if (fcnt !== 32'd0) begin errors++; $display("FAIL perf_off_flush got %h want 0", fcnt); end
        tick();
`endif
    endtask

    task automatic test_random();
        logic [9:0] e;
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            drive((mem && ($urandom_range(0, 4) != 0)) || ($urandom_range(0, 7) == 0),
                  $urandom_range(0, 5) == 0,
                  $urandom_range(0, 4) == 0,
                  $urandom_range(0, 2) == 0);
            e = exp_ctrl();
            checks++; if (act !== e) begin errors++; $display("FAIL rand_ctrl[%0d] got %b want %b", i, act, e); end
            checks++; if (stall !== (e != P_NONE)) begin errors++; $display("FAIL rand_stall[%0d] got %b", i, stall); end
            checks++; if (tmo !== m_to) begin errors++; $display("FAIL rand_timeout[%0d] got %b want %b", i, tmo, m_to); end
            checks++; if (scnt !== exp_scnt()) begin errors++; $display("FAIL rand_stall_cnt[%0d] got %0d want %0d", i, scnt, exp_scnt()); end
            checks++; if (fcnt !== exp_fcnt()) begin errors++; $display("FAIL rand_flush_cnt[%0d] got %0d want %0d", i, fcnt, exp_fcnt()); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_mem_flush();
        test_all_three();
        test_timeout();
        test_reset_mid_stall();
        test_perf_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL sim_time_limit reached without completing");
        $fatal(1, "time limit");
    end

endmodule
